calc_seq_ctrl: RTL and testbench

//  Parametrised control unit for the full calculator datapath; successor to the fixed-latency CU.

---
 rtl/calc_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
// Control sequencer for the calculator datapath: small calculator, multiplier pipeline, divider.
// Optional handshake timeout is compiled in when CALC_SEQ_TIMEOUT_EN is defined.
module calc_seq_ctrl #(
   parameter int unsigned PIPE_DEPTH = 4,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned TIMEOUT    = 200
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       Go,
   input  logic [2:0] F_Q,
   input  logic       sm_calc_Done,
   input  logic       div_Done,
   input  logic       div_Err,
   output logic       F_en,
   output logic       X_en,
   output logic       Y_en,
   output logic [1:0] Y_sel,
   output logic       sm_calc_Go,
   output logic [1:0] sm_calc_Op,
   output logic       mul_en,
   output logic       div_Go,
   output logic [1:0] Sel_H,
   output logic [1:0] Sel_L,
   output logic       OutH_en,
   output logic       OutL_en,
   output logic       Done,
   output logic       Busy,
   output logic       Err,
   output logic [3:0] CS
);

   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StLoad    = 4'd1,
      StDecode  = 4'd2,
      StSmGo    = 4'd3,
      StSmWait  = 4'd4,
      StMulRun  = 4'd5,
      StMulWb   = 4'd6,
      StDivGo   = 4'd7,
      StDivWait = 4'd8,
      StDone    = 4'd9
   } state_e;

   localparam logic [CNT_W-1:0] MulLast = CNT_W'(PIPE_DEPTH - 1);
`ifdef CALC_SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] WaitLast = CNT_W'(TIMEOUT - 1);
`endif

   if (PIPE_DEPTH < 1 || 64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_param_check
      $fatal(1, "calc_seq_ctrl: PIPE_DEPTH must be >= 1 and TIMEOUT < 2**CNT_W");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [1:0]       sm_op;

   assign sm_op = F_Q[0] ? 2'b10 : 2'b11;
   assign Err   = err_q;
   assign CS    = state_q;

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      err_d      = err_q;
      F_en       = 1'b0;
      X_en       = 1'b0;
      Y_en       = 1'b0;
      Y_sel      = 2'b00;
      sm_calc_Go = 1'b0;
      sm_calc_Op = 2'b00;
      mul_en     = 1'b0;
      div_Go     = 1'b0;
      Sel_H      = 2'b00;
      Sel_L      = 2'b00;
      OutH_en    = 1'b0;
      OutL_en    = 1'b0;
      Done       = 1'b0;
      Busy       = 1'b0;

      case (state_q)
         StIdle: begin
            // Err is cleared as LOAD is entered so it reads 0 throughout the new operation
            if (Go) begin
               state_d = StLoad;
               err_d   = 1'b0;
            end
         end
         StLoad: begin
            Busy    = 1'b1;
            F_en    = 1'b1;
            X_en    = 1'b1;
            Y_en    = 1'b1;
            Y_sel   = 2'b10;
            state_d = StDecode;
         end
         StDecode: begin
            Busy = 1'b1;
            case (F_Q)
               3'b000, 3'b001: state_d = StSmGo;
               3'b010:         state_d = StDivGo;
               3'b100, 3'b101: begin
                  Y_en    = 1'b1;
                  Y_sel   = 2'b01;
                  state_d = StMulRun;
               end
               3'b110: begin
                  Y_en    = 1'b1;
                  Y_sel   = 2'b11;
                  state_d = StMulRun;
               end
               default: begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end
            endcase
         end
         StSmGo: begin
            Busy       = 1'b1;
            sm_calc_Go = 1'b1;
            sm_calc_Op = sm_op;
            state_d    = StSmWait;
         end
         StSmWait: begin
            Busy       = 1'b1;
            sm_calc_Op = sm_op;
            if (sm_calc_Done) begin
               Sel_L   = 2'b11;
               OutL_en = 1'b1;
               state_d = StDone;
            end
`ifdef CALC_SEQ_TIMEOUT_EN
            else if (cnt_q == WaitLast) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         StMulRun: begin
            Busy   = 1'b1;
            mul_en = 1'b1;
            if (cnt_q == MulLast) begin
               state_d = StMulWb;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StMulWb: begin
            Busy    = 1'b1;
            Sel_H   = 2'b10;
            Sel_L   = 2'b11;
            OutH_en = 1'b1;
            OutL_en = 1'b1;
            state_d = StDone;
         end
         StDivGo: begin
            Busy    = 1'b1;
            div_Go  = 1'b1;
            state_d = StDivWait;
         end
         StDivWait: begin
            Busy = 1'b1;
            if (div_Done) begin
               // A divide-by-zero leaves the output registers untouched
               if (!div_Err) begin
                  Sel_H   = 2'b10;
                  Sel_L   = 2'b01;
                  OutH_en = 1'b1;
                  OutL_en = 1'b1;
               end
               err_d   = div_Err;
               state_d = StDone;
            end
`ifdef CALC_SEQ_TIMEOUT_EN
            else if (cnt_q == WaitLast) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         StDone: begin
            Busy    = 1'b1;
            Done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: vector table, hand-written corner cases and random
// transactions scored against a transaction-level model (timeout cases under CALC_SEQ_TIMEOUT_EN).
module tb_calc_seq_ctrl;

   localparam int unsigned P  = 4;
   localparam int unsigned TO = 10;

   logic       CLK = 1'b0;
   logic       rst, Go, sm_calc_Done, div_Done, div_Err;
   logic [2:0] F_Q;
   logic       F_en, X_en, Y_en, sm_calc_Go, mul_en, div_Go, OutH_en, OutL_en, Done, Busy, Err;
   logic [1:0] Y_sel, sm_calc_Op, Sel_H, Sel_L;
   logic [3:0] CS;
   logic [22:0] all_out;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   assign all_out = {F_en, X_en, Y_en, Y_sel, sm_calc_Go, sm_calc_Op, mul_en, div_Go, Sel_H,
                     Sel_L, OutH_en, OutL_en, Done, Busy, Err, CS};

   calc_seq_ctrl #(.PIPE_DEPTH(P), .CNT_W(8), .TIMEOUT(TO)) dut (
      .CLK(CLK), .rst(rst), .Go(Go), .F_Q(F_Q), .sm_calc_Done(sm_calc_Done),
      .div_Done(div_Done), .div_Err(div_Err), .F_en(F_en), .X_en(X_en), .Y_en(Y_en),
      .Y_sel(Y_sel), .sm_calc_Go(sm_calc_Go), .sm_calc_Op(sm_calc_Op), .mul_en(mul_en),
      .div_Go(div_Go), .Sel_H(Sel_H), .Sel_L(Sel_L), .OutH_en(OutH_en), .OutL_en(OutL_en),
      .Done(Done), .Busy(Busy), .Err(Err), .CS(CS)
   );

   typedef struct {
      int lat; int done_n; int err_done; int err_load; int err_idle; int sm_go_n; int sm_op;
      int div_go_n; int mul_en_n; int outl_n; int outh_n; int sel_h; int sel_l;
      int yen_dec; int ysel_dec; int load_ok; int busy_ok; int cs_done; int idle_ok;
   } obs_t;

   typedef struct {
      logic [2:0] op; int dly; logic derr; int lat; int err; int outl; int outh;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, $signed(got), $signed(exp));
      end
   endtask

   function automatic obs_t obs_init();
      obs_t o;
      o.lat = -1; o.done_n = 0; o.err_done = 0; o.err_load = 0; o.err_idle = 0;
      o.sm_go_n = 0; o.sm_op = -1; o.div_go_n = 0; o.mul_en_n = 0; o.outl_n = 0;
      o.outh_n = 0; o.sel_h = -1; o.sel_l = -1; o.yen_dec = 0; o.ysel_dec = 0;
      o.load_ok = 0; o.busy_ok = 0; o.cs_done = -1; o.idle_ok = 0;
      return o;
   endfunction

   // Expected observation of one operation, derived from the op table and timing rules
   function automatic obs_t model(input logic [2:0] op, input int dly, input logic derr);
      obs_t m;
      bit addsub, is_div, is_mul, timed_out;
      m = obs_init();
      addsub    = (op == 3'b000 || op == 3'b001);
      is_div    = (op == 3'b010);
      is_mul    = (op == 3'b100 || op == 3'b101 || op == 3'b110);
      timed_out = 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
      timed_out = (addsub || is_div) && (dly < 0 || dly > int'(TO));
`endif
      m.done_n = 1; m.load_ok = 1; m.busy_ok = 1; m.cs_done = 9; m.idle_ok = 1;
      if (addsub || is_div) m.lat = timed_out ? 4 + int'(TO) : 4 + dly;
      else if (is_mul)      m.lat = int'(P) + 4;
      else                  m.lat = 3;
      m.err_done = (!(addsub || is_div || is_mul) || timed_out || (is_div && derr)) ? 1 : 0;
      m.err_idle = m.err_done;
      if (addsub) begin m.sm_go_n = 1; m.sm_op = op[0] ? 2 : 3; end
      if (is_div) m.div_go_n = 1;
      if (is_mul) begin
         m.mul_en_n = int'(P);
         m.outl_n = 1; m.outh_n = 1; m.sel_h = 2; m.sel_l = 3;
         m.yen_dec = 1; m.ysel_dec = (op == 3'b110) ? 3 : 1;
      end
      if (addsub && !timed_out) begin m.outl_n = 1; m.sel_h = 0; m.sel_l = 3; end
      if (is_div && !derr && !timed_out) begin
         m.outl_n = 1; m.outh_n = 1; m.sel_h = 2; m.sel_l = 1;
      end
      return m;
   endfunction

   // Starts in an IDLE cycle, runs one operation, ends in the following IDLE cycle.
   // dly: cycles from the unit's Go pulse to its done pulse (<0 = never).
   task automatic run_txn(input logic [2:0] op, input int dly, input logic derr, input bit junk,
                          input bit hold_go, output obs_t o);
      int  sm_at, div_at;
      bit  fin;
      o = obs_init();
      o.busy_ok = 1;
      sm_at = -1; div_at = -1; fin = 0;
      F_Q = op;
      Go  = 1'b1;
      for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
         @(posedge CLK);
         #1;
         Go = hold_go ? 1'b1 : (junk ? 1'($urandom_range(1)) : 1'b0);
         if ((op == 3'b000 || op == 3'b001) && sm_at >= 0)
            sm_calc_Done = (dly >= 0 && cyc == sm_at + dly);
         else
            sm_calc_Done = junk && ($urandom_range(3) == 0);
         if (op == 3'b010 && div_at >= 0) begin
            div_Done = (dly >= 0 && cyc == div_at + dly);
            div_Err  = div_Done && derr;
         end else begin
            div_Done = junk && ($urandom_range(3) == 0);
            div_Err  = junk && ($urandom_range(1) == 1);
         end
         #1;
         if (sm_calc_Go) begin o.sm_go_n++; o.sm_op = int'(sm_calc_Op); sm_at = cyc; end
         if (div_Go) begin o.div_go_n++; div_at = cyc; end
         if (mul_en) o.mul_en_n++;
         if (OutL_en) o.outl_n++;
         if (OutH_en) o.outh_n++;
         if (OutL_en || OutH_en) begin o.sel_h = int'(Sel_H); o.sel_l = int'(Sel_L); end
         if (!Busy) o.busy_ok = 0;
         if (cyc == 1) begin
            o.err_load = int'(Err);
            o.load_ok  = (F_en && X_en && Y_en && Y_sel == 2'b10) ? 1 : 0;
         end
         if (cyc == 2) begin o.yen_dec = int'(Y_en); o.ysel_dec = int'(Y_sel); end
         if (Done) begin
            o.done_n++; o.lat = cyc; o.err_done = int'(Err); o.cs_done = int'(CS); fin = 1;
         end
      end
      @(posedge CLK);
      #1;
      Go = hold_go; sm_calc_Done = 1'b0; div_Done = 1'b0; div_Err = 1'b0;
      #1;
      if (Done) o.done_n++;
      o.idle_ok  = (CS == 4'd0 && !Busy) ? 1 : 0;
      o.err_idle = int'(Err);
   endtask

   task automatic check_obs(input string tag, input obs_t o, input obs_t m);
      chk({tag, " latency"}, o.lat, m.lat);
      chk({tag, " done_count"}, o.done_n, m.done_n);
      chk({tag, " err_at_done"}, o.err_done, m.err_done);
      chk({tag, " err_in_load"}, o.err_load, m.err_load);
      chk({tag, " err_held_idle"}, o.err_idle, m.err_idle);
      chk({tag, " sm_go_pulses"}, o.sm_go_n, m.sm_go_n);
      chk({tag, " sm_op"}, o.sm_op, m.sm_op);
      chk({tag, " div_go_pulses"}, o.div_go_n, m.div_go_n);
      chk({tag, " mul_en_cycles"}, o.mul_en_n, m.mul_en_n);
      chk({tag, " outl_writes"}, o.outl_n, m.outl_n);
      chk({tag, " outh_writes"}, o.outh_n, m.outh_n);
      chk({tag, " sel_h"}, o.sel_h, m.sel_h);
      chk({tag, " sel_l"}, o.sel_l, m.sel_l);
      chk({tag, " y_en_decode"}, o.yen_dec, m.yen_dec);
      chk({tag, " y_sel_decode"}, o.ysel_dec, m.ysel_dec);
      chk({tag, " load_enables"}, o.load_ok, m.load_ok);
      chk({tag, " busy"}, o.busy_ok, m.busy_ok);
      chk({tag, " cs_done"}, o.cs_done, m.cs_done);
      chk({tag, " back_to_idle"}, o.idle_ok, m.idle_ok);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[9];
      obs_t o;
      int   n;
      logic [2:0] rop;
      int   rdly;
      logic rderr;

      vecs[0] = '{3'b000, 3, 1'b0, 7, 0, 1, 0};
      vecs[1] = '{3'b001, 1, 1'b0, 5, 0, 1, 0};
      vecs[2] = '{3'b010, 2, 1'b0, 6, 0, 1, 1};
      vecs[3] = '{3'b010, 4, 1'b1, 8, 1, 0, 0};
      vecs[4] = '{3'b100, 0, 1'b0, 8, 0, 1, 1};
      vecs[5] = '{3'b101, 0, 1'b0, 8, 0, 1, 1};
      vecs[6] = '{3'b110, 0, 1'b0, 8, 0, 1, 1};
      vecs[7] = '{3'b011, 0, 1'b0, 3, 1, 0, 0};
      vecs[8] = '{3'b111, 0, 1'b0, 3, 1, 0, 0};

      rst = 1'b1; Go = 1'b0; F_Q = 3'b000;
      sm_calc_Done = 1'b0; div_Done = 1'b0; div_Err = 1'b0;
      repeat (3) @(posedge CLK);
      #2;
      chk("reset outputs", 32'(all_out), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_txn(vecs[i].op, vecs[i].dly, vecs[i].derr, 1'b0, 1'b0, o);
         chk($sformatf("vec%0d latency_const", i), o.lat, vecs[i].lat);
         chk($sformatf("vec%0d err_const", i), o.err_done, vecs[i].err);
         chk($sformatf("vec%0d outl_const", i), o.outl_n, vecs[i].outl);
         chk($sformatf("vec%0d outh_const", i), o.outh_n, vecs[i].outh);
         check_obs($sformatf("vec%0d", i), o, model(vecs[i].op, vecs[i].dly, vecs[i].derr));
      end

      // Reset while the multiplier runs: back to IDLE with Err cleared and no Done
      F_Q = 3'b100; Go = 1'b1;
      repeat (4) begin @(posedge CLK); #1; Go = 1'b0; end
      #1;
      chk("mul_run reached", 32'(CS), 32'd5);
      rst = 1'b1;
      @(posedge CLK);
      #2;
      chk("abort outputs", 32'(all_out), 32'd0);
      rst = 1'b0;
      n = 0;
      repeat (10) begin @(posedge CLK); #2; if (Done) n++; end
      chk("abort no done", n, 0);

      // Go held high through a divide: ignored while busy, restarts once from IDLE
      run_txn(3'b010, 6, 1'b0, 1'b0, 1'b1, o);
      check_obs("held_go div", o, model(3'b010, 6, 1'b0));
      @(posedge CLK);
      #2;
      chk("held_go restart", 32'(CS), 32'd1);
      rst = 1'b1; Go = 1'b0;
      @(posedge CLK);
      #1;
      rst = 1'b0;

`ifdef CALC_SEQ_TIMEOUT_EN
      run_txn(3'b000, -1, 1'b0, 1'b0, 1'b0, o);
      check_obs("timeout sm", o, model(3'b000, -1, 1'b0));
      run_txn(3'b001, int'(TO), 1'b0, 1'b0, 1'b0, o);
      check_obs("timeout done_wins", o, model(3'b001, int'(TO), 1'b0));
      run_txn(3'b010, -1, 1'b0, 1'b0, 1'b0, o);
      check_obs("timeout div", o, model(3'b010, -1, 1'b0));
`endif

      for (int i = 0; i < 40; i++) begin
         rop   = 3'($urandom_range(7));
         rdly  = int'($urandom_range(8, 1));
         rderr = 1'($urandom_range(1));
         run_txn(rop, rdly, rderr, 1'b1, 1'b0, o);
         check_obs($sformatf("rnd%0d op%0d", i, rop), o, model(rop, rdly, rderr));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
